// File: rtl/sram_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the shared word SRAM.
// The slave modport is the arbiter's view; master is the requester/SRAM environment.
interface sram_arbiter_if;
    logic        p0_req,    p1_req,    p2_req;
    logic        p0_we,     p1_we,     p2_we;
    logic        p0_lock,   p1_lock,   p2_lock;
    logic [19:0] p0_addr,   p1_addr,   p2_addr;
    logic [31:0] p0_wdata,  p1_wdata,  p2_wdata;
    logic [3:0]  p0_be,     p1_be,     p2_be;
    logic        p0_gnt,    p1_gnt,    p2_gnt;
    logic        p0_rvalid, p1_rvalid, p2_rvalid;
    logic [31:0] p0_rdata,  p1_rdata,  p2_rdata;

    logic [19:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
        input  p0_lock, p1_lock, p2_lock, p0_addr, p1_addr, p2_addr,
        input  p0_wdata, p1_wdata, p2_wdata, p0_be, p1_be, p2_be,
        output p0_gnt, p1_gnt, p2_gnt, p0_rvalid, p1_rvalid, p2_rvalid,
        output p0_rdata, p1_rdata, p2_rdata,
        output mem_addr, mem_we, mem_re, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
        output p0_lock, p1_lock, p2_lock, p0_addr, p1_addr, p2_addr,
        output p0_wdata, p1_wdata, p2_wdata, p0_be, p1_be, p2_be,
        input  p0_gnt, p1_gnt, p2_gnt, p0_rvalid, p1_rvalid, p2_rvalid,
        input  p0_rdata, p1_rdata, p2_rdata,
        input  mem_addr, mem_we, mem_re, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Three-port round-robin arbiter for the shared single-port word SRAM.
// Grants are combinational; read data returns one cycle after a read grant.
module sram_arbiter #(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int unsigned N_PORTS = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;

    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] we;
    logic [N_PORTS-1:0] lock;
    logic [ADDR_W-1:0]  addr  [N_PORTS];
    logic [DATA_W-1:0]  wdata [N_PORTS];
    logic [BE_W-1:0]    be    [N_PORTS];

    logic [IDX_W-1:0] last_q,       last_d;
    logic [CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
    logic [IDX_W-1:0] lock_owner_q, lock_owner_d;
    logic             rd_pend_q,    rd_pend_d;
    logic [IDX_W-1:0] rd_port_q,    rd_port_d;

    logic               lock_act;
    logic               gnt_any;
    logic               found;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   cand;
    logic [N_PORTS-1:0] gnt_vec;
    logic [N_PORTS-1:0] rvalid_vec;

    // Gather the per-port interface signals into indexable form.
    always_comb begin
        req      = {bus.p2_req,  bus.p1_req,  bus.p0_req};
        we       = {bus.p2_we,   bus.p1_we,   bus.p0_we};
        lock     = {bus.p2_lock, bus.p1_lock, bus.p0_lock};
        addr[0]  = bus.p0_addr;
        addr[1]  = bus.p1_addr;
        addr[2]  = bus.p2_addr;
        wdata[0] = bus.p0_wdata;
        wdata[1] = bus.p1_wdata;
        wdata[2] = bus.p2_wdata;
        be[0]    = bus.p0_be;
        be[1]    = bus.p1_be;
        be[2]    = bus.p2_be;
    end

    // Grant decision: an unexpired lock owner wins, else round-robin after last.
    always_comb begin
        lock_act = (lock_cnt_q != '0) && (lock_cnt_q < CNT_W'(LOCK_MAX));
        gnt_any  = |req;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = '0;
        if (lock_act && req[lock_owner_q]) begin
            gnt_idx = lock_owner_q;
        end else begin
            for (int k = 1; k <= int'(N_PORTS); k++) begin
                cand = IDX_W'((int'(last_q) + k) % int'(N_PORTS));
                if (!found && req[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        gnt_vec = gnt_any ? (N_PORTS'(1) << gnt_idx) : '0;
    end

    // SRAM command for the granted port; everything is zero when idle.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        if (gnt_any) begin
            bus.mem_we    = we[gnt_idx];
            bus.mem_re    = ~we[gnt_idx];
            bus.mem_addr  = {2'b00, addr[gnt_idx][ADDR_W-1:2]};
            bus.mem_wdata = wdata[gnt_idx];
            bus.mem_be    = we[gnt_idx] ? be[gnt_idx] : '0;
        end
    end

    // Next-state for round-robin pointer, lock tracking and read return.
    always_comb begin
        last_d       = last_q;
        lock_cnt_d   = '0;
        lock_owner_d = lock_owner_q;
        rd_pend_d    = 1'b0;
        rd_port_d    = rd_port_q;
        if (gnt_any) begin
            last_d    = gnt_idx;
            rd_pend_d = ~we[gnt_idx];
            rd_port_d = gnt_idx;
            if (lock[gnt_idx]) begin
                if (lock_act && (lock_owner_q == gnt_idx)) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end else begin
                    lock_owner_d = gnt_idx;
                    lock_cnt_d   = CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q       <= IDX_W'(2);
            lock_cnt_q   <= '0;
            lock_owner_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_port_q    <= '0;
        end else begin
            last_q       <= last_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_owner_q <= lock_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_port_q    <= rd_port_d;
        end
    end

    assign rvalid_vec = rd_pend_q ? (N_PORTS'(1) << rd_port_q) : '0;

    assign bus.p0_gnt    = gnt_vec[0];
    assign bus.p1_gnt    = gnt_vec[1];
    assign bus.p2_gnt    = gnt_vec[2];
    assign bus.p0_rvalid = rvalid_vec[0];
    assign bus.p1_rvalid = rvalid_vec[1];
    assign bus.p2_rvalid = rvalid_vec[2];
    assign bus.p0_rdata  = bus.mem_rdata;
    assign bus.p1_rdata  = bus.mem_rdata;
    assign bus.p2_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus a randomized run against a
// behavioural arbitration/memory model. Includes a simple registered SRAM.
module tb_sram_arbiter;
    localparam int unsigned TB_LOCK_MAX = 4;
    localparam int unsigned MEM_WORDS   = 262144;

    logic clk;
    logic rst;
    logic preload;
    int   n_checks;
    int   n_fail;

    sram_arbiter_if bus ();

    sram_arbiter #(.LOCK_MAX(TB_LOCK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port SRAM; a few low words are preloaded at start.
    bit [31:0] sram [MEM_WORDS];

    function automatic logic [31:0] init_word(input int w);
        return 32'hC0DE_0000 + 32'(w);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int w = 0; w < 4; w++) sram[w] <= init_word(w);
        end else begin
            if (bus.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) sram[bus.mem_addr[17:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr[17:0]];
        end
    end

    // Stimulus and observation helpers.
    task automatic set_port(input int p, input logic r, input logic w, input logic l,
                            input logic [19:0] a, input logic [31:0] d, input logic [3:0] b);
        case (p)
            0: begin bus.p0_req = r; bus.p0_we = w; bus.p0_lock = l; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_be = b; end
            1: begin bus.p1_req = r; bus.p1_we = w; bus.p1_lock = l; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_be = b; end
            default: begin bus.p2_req = r; bus.p2_we = w; bus.p2_lock = l; bus.p2_addr = a; bus.p2_wdata = d; bus.p2_be = b; end
        endcase
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
    endtask

    function automatic logic [2:0] gv();
        return {bus.p2_gnt, bus.p1_gnt, bus.p0_gnt};
    endfunction

    function automatic logic [2:0] rv();
        return {bus.p2_rvalid, bus.p1_rvalid, bus.p0_rvalid};
    endfunction

    function automatic logic [31:0] rd(input int p);
        case (p)
            0:       return bus.p0_rdata;
            1:       return bus.p1_rdata;
            default: return bus.p2_rdata;
        endcase
    endfunction

    function automatic logic [76:0] mem_cmd();
        return {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.mem_be};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 1'b0, 20'(4 * p), 32'h0, 4'hF);
        #1;
        n_checks++; if (gv() !== 3'b001) begin n_fail++; $display("FAIL reset_gnt: got %b want 001", gv()); end
        n_checks++; if (mem_cmd() !== {1'b0, 1'b1, 20'h0, 32'h0, 4'h0}) begin n_fail++; $display("FAIL reset_mem: got %h", mem_cmd()); end
        n_checks++; if (rv() !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 000", rv()); end
        clear_inputs();
        @(negedge clk); #1;
        n_checks++; if (gv() !== 3'b000) begin n_fail++; $display("FAIL reset_idle_gnt: got %b want 000", gv()); end
        n_checks++; if (mem_cmd() !== 77'h0) begin n_fail++; $display("FAIL reset_idle_mem: got %h want 0", mem_cmd()); end
        n_checks++; if (rv() !== 3'b000) begin n_fail++; $display("FAIL reset_hold_rvalid: got %b want 000", rv()); end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [2:0] eg, er;
        do_reset();
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 1'b0, 20'(4 * p), 32'h0, 4'hF);
        #1;
        for (int c = 0; c < 7; c++) begin
            eg = 3'(1 << (c % 3));
            er = (c == 0) ? 3'b000 : 3'(1 << ((c - 1) % 3));
            n_checks++; if (gv() !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gv(), eg); end
            n_checks++; if (bus.mem_addr !== 20'(c % 3)) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", c, bus.mem_addr, c % 3); end
            n_checks++; if (rv() !== er) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", c, rv(), er); end
            if (c > 0) begin
                n_checks++;
                if (rd((c - 1) % 3) !== init_word((c - 1) % 3)) begin
                    n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", c, rd((c - 1) % 3), init_word((c - 1) % 3));
                end
            end
            @(negedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        set_port(1, 1'b1, 1'b1, 1'b0, 20'h00010, 32'hDEADBEEF, 4'b0101);
        #1;
        n_checks++; if (gv() !== 3'b010) begin n_fail++; $display("FAIL wr_gnt: got %b want 010", gv()); end
        n_checks++; if (mem_cmd() !== {1'b1, 1'b0, 20'h00004, 32'hDEADBEEF, 4'b0101}) begin n_fail++; $display("FAIL wr_mem: got %h", mem_cmd()); end
        @(negedge clk);
        set_port(1, 1'b1, 1'b0, 1'b0, 20'h00010, 32'h0, 4'b0101);
        #1;
        n_checks++; if (mem_cmd() !== {1'b0, 1'b1, 20'h00004, 32'h0, 4'b0000}) begin n_fail++; $display("FAIL rd_mem: got %h", mem_cmd()); end
        n_checks++; if (rv() !== 3'b000) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 000", rv()); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (rv() !== 3'b010) begin n_fail++; $display("FAIL wr_rvalid: got %b want 010", rv()); end
        n_checks++; if (bus.p1_rdata !== 32'h00AD00EF) begin n_fail++; $display("FAIL wr_rdata: got %h want 00ad00ef", bus.p1_rdata); end
    endtask

    task automatic test_lock();
        int exp_seq [14] = '{0, 1, 2, 2, 2, 2, 0, 1, 2, 2, 2, 2, 0, 1};
        int streak, max_streak;
        streak = 0; max_streak = 0;
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        set_port(1, 1'b1, 1'b0, 1'b0, 20'h4, 32'h0, 4'h0);
        set_port(2, 1'b1, 1'b0, 1'b1, 20'h8, 32'h0, 4'h0);
        #1;
        for (int c = 0; c < 14; c++) begin
            n_checks++;
            if (gv() !== 3'(1 << exp_seq[c])) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b want port %0d", c, gv(), exp_seq[c]); end
            streak = (gv() === 3'b100) ? streak + 1 : 0;
            if (streak > max_streak) max_streak = streak;
            @(negedge clk); #1;
        end
        n_checks++; if (max_streak > int'(TB_LOCK_MAX)) begin n_fail++; $display("FAIL lock_streak: got %0d want <= %0d", max_streak, TB_LOCK_MAX); end
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        #1;
        for (int c = 0; c < 8; c++) begin
            n_checks++; if (gv() !== 3'b001) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b want 001", c, gv()); end
            if (c > 0) begin
                n_checks++; if (rv() !== 3'b001) begin n_fail++; $display("FAIL single_rvalid[%0d]: got %b want 001", c, rv()); end
                n_checks++; if (bus.p0_rdata !== init_word(0)) begin n_fail++; $display("FAIL single_rdata[%0d]: got %h want %h", c, bus.p0_rdata, init_word(0)); end
            end
            @(negedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        set_port(1, 1'b1, 1'b0, 1'b0, 20'h4, 32'h0, 4'h0);
        #1;
        n_checks++; if (gv() !== 3'b010) begin n_fail++; $display("FAIL mid_gnt: got %b want 010", gv()); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (rv() !== 3'b010) begin n_fail++; $display("FAIL mid_rvalid_pre: got %b want 010", rv()); end
        rst = 1'b1;
        #1;
        n_checks++; if (rv() !== 3'b000) begin n_fail++; $display("FAIL mid_rvalid_rst: got %b want 000", rv()); end
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 1'b0, 20'(4 * p), 32'h0, 4'h0);
        #1;
        n_checks++; if (gv() !== 3'b001) begin n_fail++; $display("FAIL mid_post_gnt: got %b want 001", gv()); end
        n_checks++; if (rv() !== 3'b000) begin n_fail++; $display("FAIL mid_stale_rvalid: got %b want 000", rv()); end
        @(negedge clk); #1;
        n_checks++; if (rv() !== 3'b001) begin n_fail++; $display("FAIL mid_post_rvalid: got %b want 001", rv()); end
        clear_inputs();
    endtask

    task automatic test_boundary();
        do_reset();
        set_port(2, 1'b1, 1'b1, 1'b0, 20'hFFFFF, 32'h12345678, 4'b1000);
        #1;
        n_checks++; if (gv() !== 3'b100) begin n_fail++; $display("FAIL bnd_gnt: got %b want 100", gv()); end
        n_checks++; if (mem_cmd() !== {1'b1, 1'b0, 20'h3FFFF, 32'h12345678, 4'b1000}) begin n_fail++; $display("FAIL bnd_wr_mem: got %h", mem_cmd()); end
        @(negedge clk);
        set_port(2, 1'b1, 1'b0, 1'b0, 20'hFFFFF, 32'h12345678, 4'b1000);
        #1;
        n_checks++; if (mem_cmd() !== {1'b0, 1'b1, 20'h3FFFF, 32'h12345678, 4'b0000}) begin n_fail++; $display("FAIL bnd_rd_mem: got %h", mem_cmd()); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (rv() !== 3'b100) begin n_fail++; $display("FAIL bnd_rvalid: got %b want 100", rv()); end
        n_checks++; if (bus.p2_rdata !== 32'h12000000) begin n_fail++; $display("FAIL bnd_rdata: got %h want 12000000", bus.p2_rdata); end
    endtask

    // Reference model: arbitration rules and a shadow of the random-test words.
    int          m_last, m_owner, m_cnt, m_port;
    bit          m_pend;
    logic [31:0] m_rdata;
    logic [31:0] shadow [8];

    function automatic int model_pick(input logic [2:0] r);
        if (m_cnt > 0 && m_cnt < int'(TB_LOCK_MAX) && r[m_owner]) return m_owner;
        for (int k = 1; k <= 3; k++)
            if (r[(m_last + k) % 3]) return (m_last + k) % 3;
        return -1;
    endfunction

    task automatic test_random();
        logic [2:0]  r_req, r_we, r_lock;
        logic [19:0] r_addr [3];
        logic [31:0] r_wdata [3];
        logic [3:0]  r_be [3];
        logic [2:0]  er;
        int          p, w;
        do_reset();
        m_last = 2; m_owner = 0; m_cnt = 0; m_pend = 1'b0; m_port = 0; m_rdata = '0;
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        for (int c = 0; c < 400; c++) begin
            for (int q = 0; q < 3; q++) begin
                r_req[q]   = ($urandom_range(0, 9) < 7);
                r_we[q]    = $urandom_range(0, 1) == 1;
                r_lock[q]  = ($urandom_range(0, 9) < 5);
                r_addr[q]  = 20'(((64 + $urandom_range(0, 7)) << 2) | $urandom_range(0, 3));
                r_wdata[q] = $urandom;
                r_be[q]    = 4'($urandom);
                set_port(q, r_req[q], r_we[q], r_lock[q], r_addr[q], r_wdata[q], r_be[q]);
            end
            #1;
            er = m_pend ? 3'(1 << m_port) : 3'b000;
            n_checks++; if (rv() !== er) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, rv(), er); end
            if (m_pend) begin
                n_checks++; if (rd(m_port) !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rd(m_port), m_rdata); end
            end
            p = model_pick(r_req);
            n_checks++;
            if (gv() !== ((p < 0) ? 3'b000 : 3'(1 << p))) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want port %0d", c, gv(), p); end
            n_checks++;
            if (p < 0) begin
                if (mem_cmd() !== 77'h0) begin n_fail++; $display("FAIL rnd_idle_mem[%0d]: got %h want 0", c, mem_cmd()); end
                m_cnt = 0;
                m_pend = 1'b0;
            end else begin
                if (mem_cmd() !== {r_we[p], ~r_we[p], 20'(r_addr[p] >> 2), r_wdata[p], r_we[p] ? r_be[p] : 4'h0}) begin
                    n_fail++; $display("FAIL rnd_mem[%0d]: got %h port %0d", c, mem_cmd(), p);
                end
                w = int'(r_addr[p] >> 2) - 64;
                if (r_lock[p]) begin
                    if (p == m_owner && m_cnt > 0 && m_cnt < int'(TB_LOCK_MAX)) m_cnt++;
                    else begin m_owner = p; m_cnt = 1; end
                end else m_cnt = 0;
                m_last = p;
                m_pend = ~r_we[p];
                m_port = p;
                if (r_we[p]) begin
                    for (int b = 0; b < 4; b++) if (r_be[p][b]) shadow[w][8*b +: 8] = r_wdata[p][8*b +: 8];
                end else m_rdata = shadow[w];
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        preload  = 1'b1;
        rst      = 1'b1;
        bus.mem_rdata = '0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        preload = 1'b0;
        test_round_robin();
        test_write_read();
        test_lock();
        test_single();
        test_reset_mid_read();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Three-port round-robin arbiter that shares the single-port 1 MB word SRAM between requesters: port 0 is instruction fetch, port 1 is CPU data and port 2 is DMA. It accepts at most one access per cycle and drives the SRAM command combinationally in the grant cycle. It converts byte addresses to word addresses and routes the one-cycle-latency read data back to the granted port. A bounded lock lets a requester perform an atomic read-modify-write.

## Interface
- `LOCK_MAX`, default 4: maximum consecutive grants a locking port may hold; range 1..15.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pN_req`  in  1  access request, N = 0..2; held until `pN_gnt`.
- `pN_we`  in  1  1 = write, 0 = read.
- `pN_lock`  in  1  request to retain the grant for the next access.
- `pN_addr`  in  20  byte address; bits [1:0] are ignored.
- `pN_wdata`  in  32  write data.
- `pN_be`  in  4  byte enables; writes only.
- `pN_gnt`  out  1  access issued this cycle; combinational.
- `pN_rvalid`  out  1  read data valid; registered.
- `pN_rdata`  out  32  read data; equals `mem_rdata`; qualified by `pN_rvalid`.
- `mem_addr`  out  20  SRAM word address, `{2'b00, addr[19:2]}`.
- `mem_we`, `mem_re`  out  1  SRAM write and read strobes.
- `mem_wdata`  out  32  SRAM write data.
- `mem_be`  out  4  SRAM byte enables.
- `mem_rdata`  in  32  SRAM registered read data.

## Operation
- Grant decision, combinational each cycle:
  - If a lock is active and the lock owner has `req` set, the owner wins.
  - Otherwise, requesting ports are searched in round-robin order starting at `last+1` (mod 3); the first one found wins.
- Exactly one `pN_gnt` is high when any request is present; none is high otherwise.
- The granted port's `addr`, `wdata`, `be` and `we` drive the memory:
  - `mem_we = gnt & we`.
  - `mem_re = gnt & ~we`.
  - `mem_be` is forced to 0 on reads.
- Idle cycle: `mem_we = mem_re = 0`; `mem_addr`, `mem_wdata` and `mem_be` are 0.
- `last` updates to the granted port index on every grant. It holds when idle.
- Lock state:
  - A `lock_cnt` register (4 bits) and a `lock_owner` register (2 bits) track the lock.
  - A grant with `lock=1`: if the port is already the owner, `lock_cnt += 1`; otherwise `lock_owner` = that port and `lock_cnt = 1`.
  - A grant with `lock=0`, or an idle cycle, clears the lock.
  - The lock is active only while `lock_cnt < LOCK_MAX`. When `lock_cnt == LOCK_MAX`, the next decision is plain round-robin. If the owner wins that round-robin decision while still requesting with `lock=1`, `lock_cnt` restarts at 1.
- Read return:
  - A registered `rd_pend` bit and `rd_port[1:0]` capture each read grant.
  - In the following cycle, `p[rd_port]_rvalid = 1`.
- A write and a read never complete out of order, because the memory is single-issue.

## Timing
- Reset values:
  - `last` = 2, so port 0 wins first.
  - `lock_cnt` = 0, `lock_owner` = 0, `rd_pend` = 0.
  - All `pN_rvalid` = 0.
  - Combinational outputs follow the reset-state decision.
- Grant latency: 0 cycles; `gnt` is asserted in the cycle the request is presented.
- Read latency: `rvalid` is asserted exactly 1 cycle after `gnt`.
- Back-to-back read grants produce `rvalid` on consecutive cycles, possibly to different ports.
- Throughput: one access per cycle. A continuously requesting port is served at least once every 3 grants, or once every `LOCK_MAX + 2` grants when another port locks.
- Write-then-read to the same address on consecutive cycles returns the new data, because the SRAM updates at the write edge.
- Reset asserted mid-read: `rvalid` drops immediately, and no pending read is reported after release.
- A requester that drops `req` without being granted is legal; no state changes.

## Test plan
- Reset, then all three ports request reads at addresses 0x00000, 0x00004 and 0x00008 every cycle:
  - Required grant order is 0, 1, 2, 0, …
  - `mem_addr` = 0x00000, 0x00001, 0x00002.
  - `rvalid` follows one cycle later on the matching port.
- Port 1 writes 0xDEADBEEF to byte address 0x00010 with `be` = 4'b0101, then reads it:
  - Required `p1_rdata` = 0x00AD00EF, with `p1_rvalid` asserted 1 cycle after the read `gnt`.
- With `LOCK_MAX` = 4, port 2 holds `req` and `lock` while ports 0 and 1 request continuously:
  - Port 2 receives at most 4 consecutive grants.
  - Port 0 is granted next, then port 1.
- Single requester with all other ports idle:
  - Port 0 reads every cycle and receives `gnt` every cycle.
  - `last` stays 0, and `rvalid` stays continuously high.
- Assert `rst` in the cycle after a port 1 read grant:
  - `p1_rvalid` is 0 immediately.
  - After release, port 0 wins the first contention and no stale `rvalid` appears.
- Byte address 0xFFFFF with `be` = 4'b1000 on a write:
  - `mem_addr` = 0x3FFFF and `mem_be` = 4'b1000.
  - On a read to the same address, `mem_be` = 0.
